// File: rtl/dfmul_stream_ctrl.sv
// dfmul_stream_ctrl: valid/ready streaming front-end for a fixed-latency pipelined double multiplier.
// Credit-based issue reserves a result FIFO slot for every pair sent into the multiplier.
module dfmul_stream_ctrl #(
    parameter int MUL_LAT = 2,
    parameter int DEPTH   = 8,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [63:0]      s_a,
    input  logic [63:0]      s_b,
    output logic [63:0]      mul_ina,
    output logic [63:0]      mul_inb,
    input  logic [63:0]      mul_out,
    input  logic [1:0]       mul_flag,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [63:0]      m_data,
    output logic [1:0]       m_flag,
    output logic [CNT_W-1:0] ovf_cnt,
    output logic [CNT_W-1:0] unf_cnt,
    output logic             busy
);
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FCNT_W = $clog2(DEPTH + 1);
    localparam int USED_W = FCNT_W + 1;
    localparam logic [FCNT_W-1:0] FULL    = FCNT_W'(DEPTH);
    localparam logic [USED_W-1:0] CREDITS = USED_W'(DEPTH);

    logic [MUL_LAT:0]  iss_pipe;
    logic [63:0]       fifo_data [DEPTH];
    logic [1:0]        fifo_flag [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [FCNT_W-1:0] fifo_cnt;
    logic [USED_W-1:0] used;
    logic              pop;
    logic              accept;
    logic              capture;

    assign m_valid = (fifo_cnt != '0);
    assign m_data  = m_valid ? fifo_data[rd_ptr] : '0;
    assign m_flag  = m_valid ? fifo_flag[rd_ptr] : '0;
    assign busy    = (|iss_pipe) || m_valid;

    // Slots committed after this edge: stored results plus every pair still inside the multiplier,
    // minus the entry leaving now. Independent of s_valid so s_ready never waits on the source.
    always_comb begin
        pop     = m_valid && m_ready;
        used    = USED_W'(fifo_cnt) + USED_W'($countones(iss_pipe)) - USED_W'(pop);
        s_ready = (used < CREDITS);
        accept  = s_valid && s_ready && !flush;
        capture = iss_pipe[MUL_LAT] && !flush;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            iss_pipe <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (flush) begin
            iss_pipe <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            iss_pipe <= {iss_pipe[MUL_LAT-1:0], accept};
            if (capture) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            fifo_cnt <= fifo_cnt + FCNT_W'(capture) - FCNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mul_ina <= '0;
            mul_inb <= '0;
        end else if (accept) begin
            mul_ina <= s_a;
            mul_inb <= s_b;
        end
    end

    // NOTE: the storage array is deliberately not reset; m_data/m_flag are masked by m_valid,
    // so an entry is only ever visible after it has been written.
    always_ff @(posedge clk) begin
        if (capture) begin
            fifo_data[wr_ptr] <= mul_out;
            fifo_flag[wr_ptr] <= mul_flag;
        end
    end

    // Event counters survive flush; only reset clears them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_cnt <= '0;
            unf_cnt <= '0;
        end else if (capture) begin
            if (mul_flag == 2'b01 && ovf_cnt != '1) ovf_cnt <= ovf_cnt + 1'b1;
            if (mul_flag == 2'b10 && unf_cnt != '1) unf_cnt <= unf_cnt + 1'b1;
        end
    end

    a_no_capture_when_full: assert property (
        @(posedge clk) disable iff (!reset_n) !(capture && fifo_cnt == FULL)
    );

endmodule

// File: tb/tb_dfmul_stream_ctrl.sv
// tb_dfmul_stream_ctrl: directed + randomized bench with a stub 2-stage multiplier and a
// queue-based reference model of the stream controller.
module tb_dfmul_stream_ctrl;
    localparam int MUL_LAT = 2;
    localparam int DEPTH   = 8;
    localparam int CNT_W   = 16;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             flush;
    logic             s_valid;
    logic             s_ready;
    logic [63:0]      s_a;
    logic [63:0]      s_b;
    logic [63:0]      mul_ina;
    logic [63:0]      mul_inb;
    logic [63:0]      mul_out;
    logic [1:0]       mul_flag;
    logic             m_valid;
    logic             m_ready;
    logic [63:0]      m_data;
    logic [1:0]       m_flag;
    logic [CNT_W-1:0] ovf_cnt;
    logic [CNT_W-1:0] unf_cnt;
    logic             busy;

    int checks = 0;
    int errors = 0;

    dfmul_stream_ctrl #(.MUL_LAT(MUL_LAT), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
        .mul_ina(mul_ina), .mul_inb(mul_inb), .mul_out(mul_out), .mul_flag(mul_flag),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_flag(m_flag),
        .ovf_cnt(ovf_cnt), .unf_cnt(unf_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    // Multiplier behaviour: product via real arithmetic; 01 overflow to inf from finite operands,
    // 10 product flushed to zero/subnormal from nonzero operands, 11 NaN result.
    function automatic logic [65:0] ref_mul(input logic [63:0] a, input logic [63:0] b);
        logic [63:0] p;
        logic [1:0]  f;
        p = $realtobits($bitstoreal(a) * $bitstoreal(b));
        f = 2'b00;
        if (p[62:52] == 11'h7FF) begin
            if (p[51:0] != 52'd0) f = 2'b11;
            else if (a[62:52] != 11'h7FF && b[62:52] != 11'h7FF) f = 2'b01;
        end else if (p[62:52] == 11'h000 && a[62:0] != 63'd0 && b[62:0] != 63'd0) begin
            f = 2'b10;
        end
        return {f, p};
    endfunction

    logic [65:0] st1, st2;
    always @(posedge clk) begin
        st1 <= ref_mul(mul_ina, mul_inb);
        st2 <= st1;
    end
    assign mul_out  = st2[63:0];
    assign mul_flag = st2[65:64];

    typedef struct {
        logic [65:0] res;
        int          due;
    } pend_t;

    pend_t            pend[$];
    logic [65:0]      fifo_m[$];
    logic [1:0]       popped[$];
    logic [CNT_W-1:0] mdl_ovf = '0;
    logic [CNT_W-1:0] mdl_unf = '0;
    int               edge_n = 0;
    int               n_pop = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rand_op();
        logic [63:0] v;
        v[63]    = 1'($urandom_range(0, 1));
        v[62:52] = 11'($urandom_range(32'h280, 32'h57F));
        v[51:32] = 20'($urandom);
        v[31:0]  = $urandom;
        return v;
    endfunction

    // Called at a falling edge with inputs already driven; compares, advances the model, returns
    // at the next falling edge.
    task automatic tick(output bit acc);
        bit          mpop;
        pend_t       p;
        logic [65:0] r;
        #1;
        mpop = (fifo_m.size() != 0) && m_ready;
        check("m_valid", m_valid, fifo_m.size() != 0);
        check("busy", busy, (pend.size() != 0) || (fifo_m.size() != 0));
        check("s_ready", s_ready, (fifo_m.size() + pend.size() - int'(mpop)) < DEPTH);
        check("ovf_cnt", ovf_cnt, mdl_ovf);
        check("unf_cnt", unf_cnt, mdl_unf);
        if (fifo_m.size() != 0) begin
            check("m_data", m_data, fifo_m[0][63:0]);
            check("m_flag", m_flag, fifo_m[0][65:64]);
        end
        acc = s_valid && s_ready && !flush;
        if (flush) begin
            pend.delete();
            fifo_m.delete();
        end else begin
            if (mpop) begin
                popped.push_back(fifo_m[0][65:64]);
                void'(fifo_m.pop_front());
                n_pop++;
            end
            while (pend.size() != 0 && pend[0].due == edge_n) begin
                p = pend.pop_front();
                if (p.res[65:64] == 2'b01 && mdl_ovf != '1) mdl_ovf++;
                if (p.res[65:64] == 2'b10 && mdl_unf != '1) mdl_unf++;
                fifo_m.push_back(p.res);
            end
            if (acc) begin
                r = ref_mul(s_a, s_b);
                pend.push_back('{res: r, due: edge_n + MUL_LAT + 1});
            end
        end
        @(posedge clk);
        edge_n++;
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_s_ready"}, s_ready, 1);
        check({pfx, "_mul_ina"}, mul_ina, 0);
        check({pfx, "_mul_inb"}, mul_inb, 0);
        check({pfx, "_m_valid"}, m_valid, 0);
        check({pfx, "_m_data"}, m_data, 0);
        check({pfx, "_m_flag"}, m_flag, 0);
        check({pfx, "_ovf_cnt"}, ovf_cnt, 0);
        check({pfx, "_unf_cnt"}, unf_cnt, 0);
        check({pfx, "_busy"}, busy, 0);
    endtask

    task automatic wait_valid(input int limit, output int lat);
        bit a;
        lat = 0;
        while (!m_valid && lat < limit) begin
            tick(a);
            lat++;
        end
    endtask

    task automatic drain(input string tag);
        bit a;
        int n;
        s_valid = 1'b0;
        m_ready = 1'b1;
        n = 0;
        while (busy && n < 60) begin
            tick(a);
            n++;
        end
        check(tag, busy, 0);
    endtask

    initial begin
        bit          a;
        int          lat, idx, pop0, run, max_run;
        logic [63:0] pa[12];
        logic [63:0] pb[12];
        logic [65:0] r;

        reset_n = 1'b1;
        flush   = 1'b0;
        s_valid = 1'b0;
        s_a     = '0;
        s_b     = '0;
        m_ready = 1'b0;
        #2 reset_n = 1'b0;
        #1 check_reset_vals("rst0");
        @(negedge clk);
        reset_n = 1'b1;

        // Single pair 2.0 * 3.0
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_a = 64'h4000000000000000;
        s_b = 64'h4008000000000000;
        tick(a);
        check("t1_accept", a, 1);
        s_valid = 1'b0;
        wait_valid(10, lat);
        check("t1_latency", lat, MUL_LAT + 1);
        check("t1_data", m_data, 64'h4018000000000000);
        check("t1_flag", m_flag, 2'b00);
        tick(a);
        check("t1_one_cycle", m_valid, 0);

        // Backpressure with 12 distinct pairs
        for (int i = 0; i < 12; i++) begin
            pa[i] = rand_op();
            pb[i] = rand_op();
            pa[i][3:0] = 4'(i);
        end
        m_ready = 1'b0;
        idx = 0;
        pop0 = n_pop;
        for (int c = 0; c < 20; c++) begin
            s_valid = (idx < 12);
            s_a = pa[idx % 12];
            s_b = pb[idx % 12];
            tick(a);
            if (a) idx++;
        end
        check("bp_accepted", idx, DEPTH);
        check("bp_s_ready_low", s_ready, 0);
        m_ready = 1'b1;
        for (int c = 0; c < 60 && idx < 12; c++) begin
            s_valid = 1'b1;
            s_a = pa[idx];
            s_b = pb[idx];
            tick(a);
            if (a) idx++;
        end
        check("bp_all_accepted", idx, 12);
        drain("bp_drained");
        check("bp_popped", n_pop - pop0, 12);

        // Throughput: 20 back-to-back pairs
        m_ready = 1'b1;
        run = 0;
        max_run = 0;
        for (int i = 0; i < 20; i++) begin
            if (m_valid) run++; else run = 0;
            if (run > max_run) max_run = run;
            s_valid = 1'b1;
            s_a = rand_op();
            s_b = rand_op();
            tick(a);
            check("tp_accept", a, 1);
        end
        s_valid = 1'b0;
        for (int c = 0; c < 40 && busy; c++) begin
            if (m_valid) run++; else run = 0;
            if (run > max_run) max_run = run;
            tick(a);
        end
        check("tp_run", max_run, 20);
        check("tp_idle", busy, 0);

        // Overflow, underflow, NaN flags
        popped.delete();
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_a = 64'h7FE0000000000000; s_b = 64'h7FE0000000000000; tick(a);
        s_a = 64'h0010000000000000; s_b = 64'h0010000000000000; tick(a);
        s_a = 64'h7FF0000000000000; s_b = 64'h0000000000000000; tick(a);
        drain("fl_drained");
        check("fl_count", popped.size(), 3);
        if (popped.size() == 3) begin
            check("fl_flag0", popped[0], 2'b01);
            check("fl_flag1", popped[1], 2'b10);
            check("fl_flag2", popped[2], 2'b11);
        end
        check("fl_ovf", ovf_cnt, 1);
        check("fl_unf", unf_cnt, 1);

        // Saturation
        force dut.ovf_cnt = 16'hFFFF;
        #1 release dut.ovf_cnt;
        mdl_ovf = 16'hFFFF;
        s_valid = 1'b1;
        s_a = 64'h7FE0000000000000; s_b = 64'h7FF0000000000000 - 64'h0010000000000000;
        tick(a);
        drain("sat_drained");
        check("sat_ovf", ovf_cnt, 16'hFFFF);
        check("sat_unf", unf_cnt, 1);

        // Flush one cycle after three accepts; a fourth pair offered with flush is dropped
        m_ready = 1'b1;
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_a = 64'h0010000000000000 + 64'(i);
            s_b = 64'h0020000000000000;
            tick(a);
        end
        flush = 1'b1;
        s_a = 64'h0030000000000000;
        tick(a);
        flush = 1'b0;
        s_valid = 1'b0;
        check("fsh_m_valid", m_valid, 0);
        check("fsh_busy", busy, 0);
        check("fsh_s_ready", s_ready, 1);
        for (int i = 0; i < 5; i++) tick(a);
        check("fsh_unf", unf_cnt, 1);
        check("fsh_ovf", ovf_cnt, 16'hFFFF);

        // Reset with 2 pairs in flight and 3 results stored
        m_ready = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_a = rand_op();
            s_b = rand_op();
            tick(a);
        end
        s_valid = 1'b0;
        tick(a);
        #2 reset_n = 1'b0;
        #1 check_reset_vals("rst6");
        pend.delete();
        fifo_m.delete();
        mdl_ovf = '0;
        mdl_unf = '0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_a = rand_op();
        s_b = rand_op();
        r = ref_mul(s_a, s_b);
        tick(a);
        check("rs_accept", a, 1);
        s_valid = 1'b0;
        wait_valid(10, lat);
        check("rs_latency", lat, MUL_LAT + 1);
        check("rs_data", m_data, r[63:0]);
        drain("rs_drained");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
